// File: rtl/rst_seq_pkg.sv
// Reset sequencer shared definitions.
// State encoding and rst_cause bit positions.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      HOLD       = 3'd1,
      REL_BUS    = 3'd2,
      REL_PERIPH = 3'd3,
      RUN        = 3'd4,
      DBG_HOLD   = 3'd5
   } state_e;

   localparam int CAUSE_W    = 5;
   localparam int CAUSE_POR  = 0;
   localparam int CAUSE_EXT  = 1;
   localparam int CAUSE_WDT  = 2;
   localparam int CAUSE_DBG  = 3;
   localparam int CAUSE_LOCK = 4;

endpackage

// File: rtl/rst_req_sync.sv
// Two-flop synchronizer, parameterisable width.
// Flops clear to 0 on reset.
module rst_req_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two-stage capture of the asynchronous inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for lock, holds, releases bus/periph/core.
// Macro RST_SEQ_REQ_SYNC_EN adds 2-flop input synchronizers.
module rst_seq_ctrl #(
   parameter int HOLD_CYCLES     = 256,
   parameter int GAP_CYCLES      = 16,
   parameter int DBG_HOLD_CYCLES = 32,
   parameter int CNT_W           = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       req_ext,
   input  logic       req_wdt,
   input  logic       req_dbg,
   input  logic       cause_clr,
   output logic       bus_rst,
   output logic       periph_rst,
   output logic       core_rst,
   output logic       seq_done,
   output logic [4:0] rst_cause
);

   import rst_seq_pkg::*;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DBG_LAST  = CNT_W'(DBG_HOLD_CYCLES - 1);

   logic locked_s;
   logic ext_s;
   logic wdt_s;
   logic dbg_s;

`ifdef RST_SEQ_REQ_SYNC_EN
   rst_req_sync #(
      .W(4)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i ({pll_locked, req_ext, req_wdt, req_dbg}),
      .q_o ({locked_s, ext_s, wdt_s, dbg_s})
   );
`else
   assign locked_s = pll_locked;
   assign ext_s    = req_ext;
   assign wdt_s    = req_wdt;
   assign dbg_s    = req_dbg;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bus_q, bus_d;
   logic               per_q, per_d;
   logic               core_q, core_d;
   logic               done_q, done_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [CAUSE_W-1:0] set_c;
   logic [CNT_W-1:0]   cnt_inc;
   logic               lost;
   logic               freq;

   assign lost    = ~locked_s;
   assign freq    = ext_s | wdt_s;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Next-state, counter, registered-output and cause logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bus_d   = bus_q;
      per_d   = per_q;
      core_d  = core_q;
      done_d  = done_q;
      set_c   = '0;
      if (state_q != WAIT_LOCK && lost) begin
         state_d           = WAIT_LOCK;
         cnt_d             = '0;
         bus_d             = 1'b1;
         per_d             = 1'b1;
         core_d            = 1'b1;
         done_d            = 1'b0;
         set_c[CAUSE_LOCK] = 1'b1;
      end else if (state_q != WAIT_LOCK && freq) begin
         state_d          = HOLD;
         cnt_d            = '0;
         bus_d            = 1'b1;
         per_d            = 1'b1;
         core_d           = 1'b1;
         done_d           = 1'b0;
         set_c[CAUSE_EXT] = ext_s;
         set_c[CAUSE_WDT] = wdt_s;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               bus_d  = 1'b1;
               per_d  = 1'b1;
               core_d = 1'b1;
               done_d = 1'b0;
               if (locked_s) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = REL_BUS;
                  bus_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            REL_BUS: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = REL_PERIPH;
                  per_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            REL_PERIPH: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = RUN;
                  core_d  = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            RUN: begin
               if (dbg_s) begin
                  state_d          = DBG_HOLD;
                  core_d           = 1'b1;
                  done_d           = 1'b0;
                  cnt_d            = '0;
                  set_c[CAUSE_DBG] = 1'b1;
               end
            end
            DBG_HOLD: begin
               if (cnt_q == DBG_LAST) begin
                  state_d = RUN;
                  core_d  = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               bus_d   = 1'b1;
               per_d   = 1'b1;
               core_d  = 1'b1;
               done_d  = 1'b0;
            end
         endcase
      end
      cause_d = (cause_clr ? '0 : cause_q) | set_c;
   end

   // State, counter, outputs and cause register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         bus_q   <= 1'b1;
         per_q   <= 1'b1;
         core_q  <= 1'b1;
         done_q  <= 1'b0;
         cause_q <= CAUSE_W'(1) << CAUSE_POR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bus_q   <= bus_d;
         per_q   <= per_d;
         core_q  <= core_d;
         done_q  <= done_d;
         cause_q <= cause_d;
      end
   end

   assign bus_rst    = bus_q;
   assign periph_rst = per_q;
   assign core_rst   = core_q;
   assign seq_done   = done_q;
   assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl (default build).
// Vector table for power-up/wdt, directed sequences for corners.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       req_ext;
   logic       req_wdt;
   logic       req_dbg;
   logic       cause_clr;
   logic       bus_rst;
   logic       periph_rst;
   logic       core_rst;
   logic       seq_done;
   logic [4:0] rst_cause;

   int n_cmp = 0;
   int n_bad = 0;

   rst_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .req_ext    (req_ext),
      .req_wdt    (req_wdt),
      .req_dbg    (req_dbg),
      .cause_clr  (cause_clr),
      .bus_rst    (bus_rst),
      .periph_rst (periph_rst),
      .core_rst   (core_rst),
      .seq_done   (seq_done),
      .rst_cause  (rst_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       lock;
      logic       ext;
      logic       wdt;
      logic       dbg;
      logic       clr;
      int         n;
      logic [3:0] outs;
      logic [4:0] cause;
   } vec_t;

   vec_t vt[13];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input logic [3:0] exp);
      logic [3:0] got;
      got = {bus_rst, periph_rst, core_rst, seq_done};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s outs{bus,per,core,done}: got %b want %b",
                  nm, got, exp);
      end
   endtask

   task automatic chk_cause(input string nm, input logic [4:0] exp);
      n_cmp++;
      if (rst_cause !== exp) begin
         n_bad++;
         $display("FAIL %s cause: got %b want %b", nm, rst_cause, exp);
      end
   endtask

   function automatic vec_t mk(input logic lk, input logic wd,
                               input int n, input logic [3:0] o,
                               input logic [4:0] c);
      vec_t v;
      v.lock  = lk;
      v.ext   = 1'b0;
      v.wdt   = wd;
      v.dbg   = 1'b0;
      v.clr   = 1'b0;
      v.n     = n;
      v.outs  = o;
      v.cause = c;
      return v;
   endfunction

   initial begin
      // power-up from rst release; lock sampled at edge 10
      vt[0]  = mk(1'b0, 1'b0, 9,   4'b1110, 5'b00001);
      vt[1]  = mk(1'b1, 1'b0, 1,   4'b1110, 5'b00001);
      vt[2]  = mk(1'b1, 1'b0, 255, 4'b1110, 5'b00001);
      vt[3]  = mk(1'b1, 1'b0, 1,   4'b0110, 5'b00001);
      vt[4]  = mk(1'b1, 1'b0, 15,  4'b0110, 5'b00001);
      vt[5]  = mk(1'b1, 1'b0, 1,   4'b0010, 5'b00001);
      vt[6]  = mk(1'b1, 1'b0, 15,  4'b0010, 5'b00001);
      vt[7]  = mk(1'b1, 1'b0, 1,   4'b0001, 5'b00001);
      // one-cycle watchdog pulse in RUN
      vt[8]  = mk(1'b1, 1'b1, 1,   4'b1110, 5'b00101);
      vt[9]  = mk(1'b1, 1'b0, 255, 4'b1110, 5'b00101);
      vt[10] = mk(1'b1, 1'b0, 1,   4'b0110, 5'b00101);
      vt[11] = mk(1'b1, 1'b0, 16,  4'b0010, 5'b00101);
      vt[12] = mk(1'b1, 1'b0, 16,  4'b0001, 5'b00101);

      rst        = 1'b1;
      pll_locked = 1'b0;
      req_ext    = 1'b0;
      req_wdt    = 1'b0;
      req_dbg    = 1'b0;
      cause_clr  = 1'b0;
      step(5);
      chk_out("reset", 4'b1110);
      chk_cause("reset", 5'b00001);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         pll_locked = vt[i].lock;
         req_ext    = vt[i].ext;
         req_wdt    = vt[i].wdt;
         req_dbg    = vt[i].dbg;
         cause_clr  = vt[i].clr;
         step(vt[i].n);
         chk_out($sformatf("vec%0d", i), vt[i].outs);
         chk_cause($sformatf("vec%0d", i), vt[i].cause);
      end
      req_wdt = 1'b0;

      // debug core-only reset: exactly 32 cycles
      req_dbg = 1'b1;
      step(1);
      req_dbg = 1'b0;
      chk_out("dbg_enter", 4'b0010);
      chk_cause("dbg_enter", 5'b01101);
      for (int i = 0; i < 31; i++) begin
         step(1);
         chk_out($sformatf("dbg_hold%0d", i), 4'b0010);
      end
      step(1);
      chk_out("dbg_exit", 4'b0001);

      // cause_clr on the same edge as a wdt-triggered transition
      req_wdt   = 1'b1;
      cause_clr = 1'b1;
      step(1);
      req_wdt   = 1'b0;
      cause_clr = 1'b0;
      chk_out("clr_wdt", 4'b1110);
      chk_cause("clr_wdt", 5'b00100);
      step(287);
      chk_out("clr_seq_pre", 4'b0010);
      step(1);
      chk_out("clr_seq_run", 4'b0001);

      // lock loss in REL_PERIPH, then relock
      req_wdt = 1'b1;
      step(1);
      req_wdt = 1'b0;
      step(276);
      chk_out("in_rel_per", 4'b0010);
      pll_locked = 1'b0;
      step(1);
      chk_out("lost", 4'b1110);
      chk_cause("lost", 5'b10100);
      step(5);
      chk_out("wait_lock", 4'b1110);
      pll_locked = 1'b1;
      step(1);
      step(255);
      chk_out("relock_hold", 4'b1110);
      step(1);
      chk_out("relock_bus", 4'b0110);
      step(32);
      chk_out("relock_run", 4'b0001);

      // req_ext held 100 cycles; release 256 cycles after it drops
      req_ext = 1'b1;
      step(100);
      chk_out("ext_held", 4'b1110);
      chk_cause("ext_held", 5'b10110);
      req_ext = 1'b0;
      step(255);
      chk_out("ext_hold_end", 4'b1110);
      step(1);
      chk_out("ext_bus_rel", 4'b0110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
